// File: rtl/inv_bfly_r2_pipe.sv
// ---------------------------------------------------------------------------
// inv_bfly_r2_pipe
//   Pipelined inverse radix-2 DIT butterfly on packed complex Q1.15 words.
//     t    = conj(W) * in1
//     out0 = (in0 + t) / 2
//     out1 = (in0 - t) / 2
//   The /2 is the per-stage inverse-transform normalisation.
//   Three register stages, valid/ready on both sides, bubble collapse,
//   saturating count of output beats that had at least one clamped component.
//
// Build option:
//   IBFLY_ROUND_EN  defined   -> round half toward +inf (add 0x8000 before >>>16)
//                   undefined -> truncate toward -inf
//
// Parameters:
//   CNT_W      width of sat_cnt
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   in_valid / in_ready   input handshake; in0, in1, tw sampled on transfer
//   in0, in1, tw          packed {re[31:16], im[15:0]} signed Q1.15;
//                         tw is the forward twiddle, conjugated internally
//   out_valid / out_ready output handshake
//   out0, out1            packed results, held while stalled
//   sat_clr               synchronous clear of sat_cnt (wins over increment)
//   sat_cnt               saturating count of saturated output beats
// ---------------------------------------------------------------------------
module inv_bfly_r2_pipe #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in0,
  input  logic [31:0]      in1,
  input  logic [31:0]      tw,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out0,
  output logic [31:0]      out1,
  input  logic             sat_clr,
  output logic [CNT_W-1:0] sat_cnt
);

`ifdef IBFLY_ROUND_EN
  localparam logic signed [34:0] RND = 35'sd32768;
`else
  localparam logic signed [34:0] RND = '0;
`endif

  // Scale a Q.30 sum by 1/2 into Q1.15 and clamp; bit 16 flags a clamp.
  function automatic logic [16:0] scale_sat(input logic signed [34:0] x);
    logic signed [34:0] r;
    r = (x + RND) >>> 16;
    if (r > 35'sd32767)
      return {1'b1, 16'h7FFF};
    else if (r < -35'sd32768)
      return {1'b1, 16'h8000};
    else
      return {1'b0, r[15:0]};
  endfunction

  // ---------------- handshake / stage enables ----------------
  logic v1, v2, v3;
  logic load1, load2, load3;

  assign load3     = !v3 || out_ready;
  assign load2     = !v2 || load3;
  assign load1     = !v1 || load2;
  assign in_ready  = load1;
  assign out_valid = v3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
    end else begin
      if (load1) v1 <= in_valid;
      if (load2) v2 <= v1;
      if (load3) v3 <= v2;
    end
  end

  // ---------------- stage 1: products ----------------
  logic signed [31:0] a, b, wr, wi;
  assign a  = 32'(signed'(in1[31:16]));
  assign b  = 32'(signed'(in1[15:0]));
  assign wr = 32'(signed'(tw[31:16]));
  assign wi = 32'(signed'(tw[15:0]));

  logic signed [31:0] p_awr, p_bwi, p_bwr, p_awi;
  logic        [31:0] x0_s1;

  always_ff @(posedge clk) begin
    if (load1 && in_valid) begin
      p_awr <= a * wr;
      p_bwi <= b * wi;
      p_bwr <= b * wr;
      p_awi <= a * wi;
      x0_s1 <= in0;
    end
  end

  // ---------------- stage 2: conj(W)*in1, in0 alignment ----------------
  // Conjugation lives in the signs of the sums; wi itself is never negated,
  // so wi = -32768 needs no special case.
  logic signed [33:0] t_re, t_im, x0_re, x0_im;

  always_ff @(posedge clk) begin
    if (load2 && v1) begin
      t_re  <= {{2{p_awr[31]}}, p_awr} + {{2{p_bwi[31]}}, p_bwi};
      t_im  <= {{2{p_bwr[31]}}, p_bwr} - {{2{p_awi[31]}}, p_awi};
      x0_re <= {{3{x0_s1[31]}}, x0_s1[31:16], 15'b0};
      x0_im <= {{3{x0_s1[15]}}, x0_s1[15:0], 15'b0};
    end
  end

  // ---------------- stage 3: sum/diff, scale, saturate ----------------
  logic signed [34:0] s_re, s_im, d_re, d_im;
  logic        [16:0] q0_re, q0_im, q1_re, q1_im;
  logic               sat_any;

  always_comb begin
    s_re    = {x0_re[33], x0_re} + {t_re[33], t_re};
    s_im    = {x0_im[33], x0_im} + {t_im[33], t_im};
    d_re    = {x0_re[33], x0_re} - {t_re[33], t_re};
    d_im    = {x0_im[33], x0_im} - {t_im[33], t_im};
    q0_re   = scale_sat(s_re);
    q0_im   = scale_sat(s_im);
    q1_re   = scale_sat(d_re);
    q1_im   = scale_sat(d_im);
    sat_any = q0_re[16] | q0_im[16] | q1_re[16] | q1_im[16];
  end

  logic sat3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out0 <= '0;
      out1 <= '0;
      sat3 <= 1'b0;
    end else if (load3 && v2) begin
      out0 <= {q0_re[15:0], q0_im[15:0]};
      out1 <= {q1_re[15:0], q1_im[15:0]};
      sat3 <= sat_any;
    end
  end

  // ---------------- saturation event counter ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      sat_cnt <= '0;
    else if (sat_clr)
      sat_cnt <= '0;
    else if (v3 && out_ready && sat3 && (sat_cnt != '1))
      sat_cnt <= sat_cnt + 1'b1;
  end

endmodule

// File: tb/tb_inv_bfly_r2_pipe.sv
// ---------------------------------------------------------------------------
// tb_inv_bfly_r2_pipe
//   Directed self-checking bench for inv_bfly_r2_pipe. Expected values are
//   hand-computed constants; the rounding variant is chosen by IBFLY_ROUND_EN.
//   The counter is instantiated narrow so the stick-at-all-ones case is cheap.
// ---------------------------------------------------------------------------
module tb_inv_bfly_r2_pipe;

  localparam int CW = 4;

`ifdef IBFLY_ROUND_EN
  localparam logic [31:0] T1_OUT0 = 32'h3000_0000;
  localparam logic [31:0] T2_OUT1 = 32'h0000_2000;
  localparam logic [31:0] T3_OUT1 = 32'hC000_0000;
`else
  localparam logic [31:0] T1_OUT0 = 32'h2FFF_0000;
  localparam logic [31:0] T2_OUT1 = 32'h0000_1FFF;
  localparam logic [31:0] T3_OUT1 = 32'hBFFF_0000;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in0, in1, tw;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out0, out1;
  logic          sat_clr;
  logic [CW-1:0] sat_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  inv_bfly_r2_pipe #(.CNT_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in0       (in0),
    .in1       (in1),
    .tw        (tw),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out0      (out0),
    .out1      (out1),
    .sat_clr   (sat_clr),
    .sat_cnt   (sat_cnt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One beat through an empty pipe with out_ready high; reports latency in
  // negedges after the input transfer edge (0 means it never appeared).
  task automatic send_one(input logic [31:0] a0, input logic [31:0] a1,
                          input logic [31:0] w, output logic [31:0] o0,
                          output logic [31:0] o1, output int lat);
    @(negedge clk);
    in0 = a0; in1 = a1; tw = w;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    o0  = '0;
    o1  = '0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = i;
        o0  = out0;
        o1  = out1;
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] t4_exp(input int k);
    logic [15:0] re;
    re = 16'(k * 128);
    return {re, 16'(-k * 128), re, 16'(-k * 128)};
  endfunction

  logic [31:0] o0, o1;
  int          lat;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; sat_clr = 1'b0;
    in0 = '0; in1 = '0; tw = '0;
    #12;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out0",      64'(out0),      64'd0);
    check("rst_out1",      64'(out1),      64'd0);
    check("rst_sat_cnt",   64'(sat_cnt),   64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("rst_in_ready", 64'(in_ready), 64'd1);

    // T1
    send_one(32'h4000_0000, 32'h2000_0000, 32'h7FFF_0000, o0, o1, lat);
    check("t1_lat",  64'(lat), 64'd3);
    check("t1_out0", 64'(o0),  64'(T1_OUT0));
    check("t1_out1", 64'(o1),  64'h1000_0000);

    // T2: conjugate of an imaginary twiddle
    send_one(32'h0000_0000, 32'h4000_0000, 32'h0000_7FFF, o0, o1, lat);
    check("t2_lat",  64'(lat), 64'd3);
    check("t2_out0", 64'(o0),  64'h0000_E000);
    check("t2_out1", 64'(o1),  64'(T2_OUT1));

    // T3: saturation with -32768 twiddle components
    check("t3_cnt_pre", 64'(sat_cnt), 64'd0);
    send_one(32'h7FFF_0000, 32'h8000_8000, 32'h8000_8000, o0, o1, lat);
    check("t3_out0",    64'(o0),      64'h7FFF_0000);
    check("t3_out1",    64'(o1),      64'(T3_OUT1));
    check("t3_cnt",     64'(sat_cnt), 64'd1);

    // T4: 8-beat stream, out_ready low for cycles 4..9
    begin
      int          acc = 0;
      int          emit = 0;
      logic        stalled = 1'b0;
      logic [63:0] held = '0;
      for (int cyc = 0; cyc < 60 && emit < 8; cyc++) begin
        @(negedge clk);
        out_ready = !(cyc >= 4 && cyc <= 9);
        if (stalled) check("t4_hold", {out0, out1}, held);
        in_valid = (acc < 8);
        in0 = {16'((acc + 1) * 256), 16'(-(acc + 1) * 256)};
        in1 = 32'h1234_5678;
        tw  = 32'h0000_0000;
        #1;
        if (cyc == 9) begin
          check("t4_in_ready_full", 64'(in_ready), 64'd0);
          check("t4_in_flight",     64'(acc - emit), 64'd3);
        end
        if (in_valid && in_ready) acc++;
        if (out_valid && out_ready) begin
          emit++;
          check("t4_beat", {out0, out1}, t4_exp(emit));
        end
        stalled = out_valid && !out_ready;
        held    = {out0, out1};
      end
      in_valid = 1'b0;
      check("t4_count", 64'(emit), 64'd8);
    end

    // T5: reset with three beats in flight
    @(negedge clk);
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in0 = 32'h4000_0000; in1 = '0; tw = '0;
      in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("t5_pre_valid", 64'(out_valid), 64'd1);
    check("t5_pre_out0",  64'(out0),      64'h2000_0000);
    check("t5_pre_cnt",   64'(sat_cnt),   64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_out_valid", 64'(out_valid), 64'd0);
    check("t5_out0",      64'(out0),      64'd0);
    check("t5_out1",      64'(out1),      64'd0);
    check("t5_sat_cnt",   64'(sat_cnt),   64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    send_one(32'h4000_0000, 32'h2000_0000, 32'h7FFF_0000, o0, o1, lat);
    check("t5_lat",  64'(lat), 64'd3);
    check("t5_out1", 64'(o1),  64'h1000_0000);

    // T6: fill counter to all-ones, then clear against a saturating transfer
    @(negedge clk);
    out_ready = 1'b1;
    in0 = 32'h7FFF_0000; in1 = 32'h8000_8000; tw = 32'h8000_8000;
    in_valid = 1'b1;
    for (int k = 0; k < 20; k++) @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 5; k++) @(negedge clk);
    check("t6_stick", 64'(sat_cnt), 64'hF);

    out_ready = 1'b0;
    in_valid  = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    begin
      bit seen = 1'b0;
      for (int k = 0; k < 10 && !seen; k++) begin
        @(negedge clk);
        seen = out_valid;
      end
      check("t6_wait_valid", 64'(seen), 64'd1);
    end
    check("t6_pre_clr", 64'(sat_cnt), 64'hF);
    out_ready = 1'b1;
    sat_clr   = 1'b1;
    @(posedge clk);
    #1 sat_clr = 1'b0;
    check("t6_clr_wins", 64'(sat_cnt), 64'd0);
    check("t6_drained",  64'(out_valid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

endmodule
